// File: rtl/cprv_wb_arbiter.sv
// cprv_wb_arbiter: round-robin arbiter for the single register-file write port,
// with a per-register busy scoreboard for RAW/WAW hazard detection.
// Optional build macro: CPRV_WB_BYPASS_EN forwards the in-flight regfile write
// to the issue stage's source operands and masks their busy indication.

`default_nettype none

module cprv_wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 3
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  output logic [NUM_REQ-1:0]               o_req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data,
  input  logic                             i_issue_en,
  input  logic [ADDR_WIDTH-1:0]            i_issue_addr,
  input  logic [ADDR_WIDTH-1:0]            i_rs1_addr,
  input  logic [ADDR_WIDTH-1:0]            i_rs2_addr,
  output logic                             o_rs1_busy,
  output logic                             o_rs2_busy,
  output logic                             o_rd_busy,
  output logic                             o_rs1_fwd_valid,
  output logic                             o_rs2_fwd_valid,
  output logic [DATA_WIDTH-1:0]            o_rs1_fwd_data,
  output logic [DATA_WIDTH-1:0]            o_rs2_fwd_data,
  output logic [ADDR_WIDTH-1:0]            o_rf_rd_addr,
  output logic [DATA_WIDTH-1:0]            o_rf_rd_data,
  output logic                             o_rf_rd_en
);

  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  // Round-robin pointer: the requester that gets first look next cycle.
  logic [PTR_W-1:0]      r_rrPtr;
  // One pending-write bit per architectural register; bit 0 stays 0 for x0.
  logic [NUM_REGS-1:0]   r_busy;
  // Registered write stage that drives the regfile write port.
  logic                  r_rfEn;
  logic [ADDR_WIDTH-1:0] r_rfAddr;
  logic [DATA_WIDTH-1:0] r_rfData;

  logic [NUM_REQ-1:0]    w_ready;
  logic [PTR_W-1:0]      w_grantIdx;
  logic                  w_found;
  logic                  w_xfer;
  logic [PTR_W-1:0]      w_nextPtr;
  logic [ADDR_WIDTH-1:0] w_selAddr;
  logic [DATA_WIDTH-1:0] w_selData;
  logic                  w_rs1Hit;
  logic                  w_rs2Hit;

  // Rotate an offset around the pointer, wrapping at NUM_REQ rather than at a
  // power of two so non-power-of-two requester counts stay fair.
  function automatic logic [PTR_W-1:0] wrapIdx(input logic [PTR_W-1:0] base,
                                               input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  // Pick the first valid requester at or after the round-robin pointer.
  always_comb begin
    w_ready    = '0;
    w_grantIdx = '0;
    w_found    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req_valid[wrapIdx(r_rrPtr, k)]) begin
        w_found    = 1'b1;
        w_grantIdx = wrapIdx(r_rrPtr, k);
      end
    end
    if (w_found) w_ready[w_grantIdx] = 1'b1;
  end

  // The write port is always free, so any grant is also a transfer.
  assign w_xfer      = w_found;
  assign o_req_ready = w_ready;
  assign w_selAddr   = i_req_addr[w_grantIdx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_selData   = i_req_data[w_grantIdx*DATA_WIDTH +: DATA_WIDTH];
  assign w_nextPtr   = (w_grantIdx == PTR_W'(NUM_REQ - 1)) ? '0
                                                            : w_grantIdx + PTR_W'(1);

  // Advance the pointer just past the winner after each transfer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rrPtr <= '0;
    end else if (w_xfer) begin
      r_rrPtr <= w_nextPtr;
    end
  end

  // Register the winning write; x0 writes are swallowed, addr/data hold otherwise.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rfEn   <= 1'b0;
      r_rfAddr <= '0;
      r_rfData <= '0;
    end else if (w_xfer && (w_selAddr != '0)) begin
      r_rfEn   <= 1'b1;
      r_rfAddr <= w_selAddr;
      r_rfData <= w_selData;
    end else begin
      r_rfEn   <= 1'b0;
    end
  end

  assign o_rf_rd_en   = r_rfEn;
  assign o_rf_rd_addr = r_rfAddr;
  assign o_rf_rd_data = r_rfData;

  // Clear on commit, then set on issue so a new writer to the same register wins.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy <= '0;
    end else begin
      if (r_rfEn) r_busy[r_rfAddr] <= 1'b0;
      if (i_issue_en && (i_issue_addr != '0)) r_busy[i_issue_addr] <= 1'b1;
      r_busy[0] <= 1'b0;
    end
  end

`ifdef CPRV_WB_BYPASS_EN
  // The write committing this cycle already holds the value a reader needs.
  assign w_rs1Hit = r_rfEn && (r_rfAddr == i_rs1_addr) && (i_rs1_addr != '0);
  assign w_rs2Hit = r_rfEn && (r_rfAddr == i_rs2_addr) && (i_rs2_addr != '0);
  assign o_rs1_fwd_valid = w_rs1Hit;
  assign o_rs2_fwd_valid = w_rs2Hit;
  assign o_rs1_fwd_data  = w_rs1Hit ? r_rfData : '0;
  assign o_rs2_fwd_data  = w_rs2Hit ? r_rfData : '0;
`else
  assign w_rs1Hit = 1'b0;
  assign w_rs2Hit = 1'b0;
  assign o_rs1_fwd_valid = 1'b0;
  assign o_rs2_fwd_valid = 1'b0;
  assign o_rs1_fwd_data  = '0;
  assign o_rs2_fwd_data  = '0;
`endif

  // A forwarded source is no longer a hazard; the WAW check never forwards.
  assign o_rs1_busy = r_busy[i_rs1_addr] & ~w_rs1Hit;
  assign o_rs2_busy = r_busy[i_rs2_addr] & ~w_rs2Hit;
  assign o_rd_busy  = r_busy[i_issue_addr];

endmodule

`default_nettype wire

// File: tb/tb_cprv_wb_arbiter.sv
// tb_cprv_wb_arbiter: directed checks for cprv_wb_arbiter, covering both the
// default build and the CPRV_WB_BYPASS_EN build.

module tb_cprv_wb_arbiter;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 3;

  logic             i_clk;
  logic             i_rst_n;
  logic [NR-1:0]    i_req_valid;
  logic [NR-1:0]    o_req_ready;
  logic [NR*AW-1:0] i_req_addr;
  logic [NR*DW-1:0] i_req_data;
  logic             i_issue_en;
  logic [AW-1:0]    i_issue_addr;
  logic [AW-1:0]    i_rs1_addr;
  logic [AW-1:0]    i_rs2_addr;
  logic             o_rs1_busy;
  logic             o_rs2_busy;
  logic             o_rd_busy;
  logic             o_rs1_fwd_valid;
  logic             o_rs2_fwd_valid;
  logic [DW-1:0]    o_rs1_fwd_data;
  logic [DW-1:0]    o_rs2_fwd_data;
  logic [AW-1:0]    o_rf_rd_addr;
  logic [DW-1:0]    o_rf_rd_data;
  logic             o_rf_rd_en;

  int nChecks = 0;
  int nFails  = 0;

  cprv_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .i_issue_en(i_issue_en), .i_issue_addr(i_issue_addr),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy), .o_rd_busy(o_rd_busy),
    .o_rs1_fwd_valid(o_rs1_fwd_valid), .o_rs2_fwd_valid(o_rs2_fwd_valid),
    .o_rs1_fwd_data(o_rs1_fwd_data), .o_rs2_fwd_data(o_rs2_fwd_data),
    .o_rf_rd_addr(o_rf_rd_addr), .o_rf_rd_data(o_rf_rd_data),
    .o_rf_rd_en(o_rf_rd_en)
  );

  // Free-running 10 ns clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Advance one edge and settle 1 ns past it before looking at outputs.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic setReq(input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    i_req_addr[idx*AW +: AW] = addr;
    i_req_data[idx*DW +: DW] = data;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_req_valid = '0; i_req_addr = '0; i_req_data = '0;
    i_issue_en = 1'b0; i_issue_addr = '0; i_rs1_addr = '0; i_rs2_addr = '0;
    tick(); tick();
    i_rst_n = 1'b1; i_rs1_addr = 5'd5;
    #1;
    nChecks++; if (o_rf_rd_en !== 1'b0) begin nFails++; $display("[TB] FAIL reset_rf_en: got %0h expected 0", o_rf_rd_en); end
    nChecks++; if (o_rf_rd_addr !== 5'd0) begin nFails++; $display("[TB] FAIL reset_rf_addr: got %0h expected 0", o_rf_rd_addr); end
    nChecks++; if (o_rf_rd_data !== 64'd0) begin nFails++; $display("[TB] FAIL reset_rf_data: got %0h expected 0", o_rf_rd_data); end
    nChecks++; if (o_rs1_busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_rs1_busy: got %0h expected 0", o_rs1_busy); end
    nChecks++; if (o_req_ready !== 3'b000) begin nFails++; $display("[TB] FAIL reset_ready: got %b expected 000", o_req_ready); end
    nChecks++; if ({o_rs1_fwd_valid, o_rs2_fwd_valid} !== 2'b00) begin nFails++; $display("[TB] FAIL reset_fwd_valid: got %b expected 00", {o_rs1_fwd_valid, o_rs2_fwd_valid}); end
    nChecks++; if ((o_rs1_fwd_data | o_rs2_fwd_data) !== 64'd0) begin nFails++; $display("[TB] FAIL reset_fwd_data: got %0h/%0h expected 0", o_rs1_fwd_data, o_rs2_fwd_data); end
  endtask

  task automatic test_basic_write();
    i_issue_en = 1'b1; i_issue_addr = 5'd7;
    tick();
    i_issue_en = 1'b0; i_rs1_addr = 5'd7;
    #1;
    nChecks++; if (o_rs1_busy !== 1'b1) begin nFails++; $display("[TB] FAIL issue_sets_busy: got %0h expected 1", o_rs1_busy); end
    nChecks++; if (o_rd_busy !== 1'b1) begin nFails++; $display("[TB] FAIL rd_busy_waw: got %0h expected 1", o_rd_busy); end
    setReq(0, 5'd7, 64'hDEAD); i_req_valid = 3'b001;
    #1;
    nChecks++; if (o_req_ready !== 3'b001) begin nFails++; $display("[TB] FAIL basic_ready: got %b expected 001", o_req_ready); end
    tick();
    i_req_valid = 3'b000;
    #1;
    nChecks++; if (o_rf_rd_en !== 1'b1) begin nFails++; $display("[TB] FAIL basic_rf_en: got %0h expected 1", o_rf_rd_en); end
    nChecks++; if (o_rf_rd_addr !== 5'd7) begin nFails++; $display("[TB] FAIL basic_rf_addr: got %0d expected 7", o_rf_rd_addr); end
    nChecks++; if (o_rf_rd_data !== 64'hDEAD) begin nFails++; $display("[TB] FAIL basic_rf_data: got %0h expected dead", o_rf_rd_data); end
`ifdef CPRV_WB_BYPASS_EN
    nChecks++; if (o_rs1_busy !== 1'b0) begin nFails++; $display("[TB] FAIL basic_rs1_busy_bypass: got %0h expected 0", o_rs1_busy); end
    nChecks++; if (o_rs1_fwd_data !== 64'hDEAD) begin nFails++; $display("[TB] FAIL basic_rs1_fwd_data: got %0h expected dead", o_rs1_fwd_data); end
`else
    nChecks++; if (o_rs1_busy !== 1'b1) begin nFails++; $display("[TB] FAIL basic_rs1_busy_pending: got %0h expected 1", o_rs1_busy); end
`endif
    tick();
    nChecks++; if (o_rs1_busy !== 1'b0) begin nFails++; $display("[TB] FAIL basic_busy_cleared: got %0h expected 0", o_rs1_busy); end
    nChecks++; if (o_rf_rd_en !== 1'b0) begin nFails++; $display("[TB] FAIL basic_rf_en_drop: got %0h expected 0", o_rf_rd_en); end
    nChecks++; if (o_rf_rd_addr !== 5'd7) begin nFails++; $display("[TB] FAIL basic_rf_addr_hold: got %0d expected 7", o_rf_rd_addr); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] expReady;
    i_rst_n = 1'b0; tick(); i_rst_n = 1'b1;
    for (int i = 0; i < NR; i++) setReq(i, AW'(16 + i), DW'(64'hA0 + i));
    i_req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      expReady = NR'(1 << (k % 3));
      nChecks++; if (o_req_ready !== expReady) begin nFails++; $display("[TB] FAIL rr_grant_%0d: got %b expected %b", k, o_req_ready, expReady); end
      tick();
      nChecks++; if (o_rf_rd_addr !== AW'(16 + k % 3)) begin nFails++; $display("[TB] FAIL rr_rf_addr_%0d: got %0d expected %0d", k, o_rf_rd_addr, 16 + k % 3); end
    end
    i_req_valid = 3'b110;
    #1;
    nChecks++; if (o_req_ready !== 3'b010) begin nFails++; $display("[TB] FAIL rr_skip: got %b expected 010", o_req_ready); end
    tick();
    i_req_valid = 3'b011;
    #1;
    nChecks++; if (o_req_ready !== 3'b001) begin nFails++; $display("[TB] FAIL rr_wrap: got %b expected 001", o_req_ready); end
    tick();
    i_req_valid = 3'b000;
    #1;
    nChecks++; if (o_rf_rd_data !== 64'hA0) begin nFails++; $display("[TB] FAIL rr_wrap_data: got %0h expected a0", o_rf_rd_data); end
  endtask

  task automatic test_x0_write();
    i_issue_en = 1'b1; i_issue_addr = 5'd0;
    tick();
    i_issue_en = 1'b0; i_rs1_addr = 5'd0;
    #1;
    nChecks++; if (o_rd_busy !== 1'b0) begin nFails++; $display("[TB] FAIL x0_rd_busy: got %0h expected 0", o_rd_busy); end
    nChecks++; if (o_rs1_busy !== 1'b0) begin nFails++; $display("[TB] FAIL x0_rs1_busy: got %0h expected 0", o_rs1_busy); end
    setReq(1, 5'd0, 64'hFFFF); i_req_valid = 3'b010;
    #1;
    nChecks++; if (o_req_ready !== 3'b010) begin nFails++; $display("[TB] FAIL x0_ready: got %b expected 010", o_req_ready); end
    tick();
    i_req_valid = 3'b000;
    #1;
    nChecks++; if (o_rf_rd_en !== 1'b0) begin nFails++; $display("[TB] FAIL x0_rf_en: got %0h expected 0", o_rf_rd_en); end
    nChecks++; if (o_rf_rd_addr !== 5'd16) begin nFails++; $display("[TB] FAIL x0_rf_addr_hold: got %0d expected 16", o_rf_rd_addr); end
    nChecks++; if (o_rf_rd_data !== 64'hA0) begin nFails++; $display("[TB] FAIL x0_rf_data_hold: got %0h expected a0", o_rf_rd_data); end
  endtask

  task automatic test_set_clear_same();
    i_issue_en = 1'b1; i_issue_addr = 5'd9;
    tick();
    i_issue_en = 1'b0;
    setReq(2, 5'd9, 64'h99); i_req_valid = 3'b100;
    tick();
    i_req_valid = 3'b000;
    #1;
    nChecks++; if (o_rf_rd_en !== 1'b1) begin nFails++; $display("[TB] FAIL sc_rf_en: got %0h expected 1", o_rf_rd_en); end
    i_issue_en = 1'b1; i_issue_addr = 5'd9;
    tick();
    i_issue_en = 1'b0; i_rs1_addr = 5'd9;
    #1;
    nChecks++; if (o_rs1_busy !== 1'b1) begin nFails++; $display("[TB] FAIL sc_set_wins: got %0h expected 1", o_rs1_busy); end
    i_req_valid = 3'b100;
    tick();
    i_req_valid = 3'b000;
    tick();
    nChecks++; if (o_rs1_busy !== 1'b0) begin nFails++; $display("[TB] FAIL sc_final_clear: got %0h expected 0", o_rs1_busy); end
  endtask

  task automatic test_bypass();
    i_issue_en = 1'b1; i_issue_addr = 5'd4;
    tick();
    i_issue_en = 1'b0;
    setReq(0, 5'd4, 64'h1234); i_req_valid = 3'b001;
    tick();
    i_req_valid = 3'b000; i_rs2_addr = 5'd4; i_rs1_addr = 5'd0;
    #1;
`ifdef CPRV_WB_BYPASS_EN
    nChecks++; if (o_rs2_fwd_valid !== 1'b1) begin nFails++; $display("[TB] FAIL byp_fwd_valid: got %0h expected 1", o_rs2_fwd_valid); end
    nChecks++; if (o_rs2_fwd_data !== 64'h1234) begin nFails++; $display("[TB] FAIL byp_fwd_data: got %0h expected 1234", o_rs2_fwd_data); end
    nChecks++; if (o_rs2_busy !== 1'b0) begin nFails++; $display("[TB] FAIL byp_rs2_busy: got %0h expected 0", o_rs2_busy); end
`else
    nChecks++; if (o_rs2_fwd_valid !== 1'b0) begin nFails++; $display("[TB] FAIL byp_fwd_valid: got %0h expected 0", o_rs2_fwd_valid); end
    nChecks++; if (o_rs2_fwd_data !== 64'd0) begin nFails++; $display("[TB] FAIL byp_fwd_data: got %0h expected 0", o_rs2_fwd_data); end
    nChecks++; if (o_rs2_busy !== 1'b1) begin nFails++; $display("[TB] FAIL byp_rs2_busy: got %0h expected 1", o_rs2_busy); end
`endif
    nChecks++; if (o_rs1_fwd_valid !== 1'b0) begin nFails++; $display("[TB] FAIL byp_rs1_x0: got %0h expected 0", o_rs1_fwd_valid); end
    tick();
    nChecks++; if (o_rs2_busy !== 1'b0) begin nFails++; $display("[TB] FAIL byp_after_commit: got %0h expected 0", o_rs2_busy); end
    nChecks++; if (o_rs2_fwd_valid !== 1'b0) begin nFails++; $display("[TB] FAIL byp_fwd_drop: got %0h expected 0", o_rs2_fwd_valid); end
  endtask

  task automatic test_reset_mid();
    i_issue_en = 1'b1; i_issue_addr = 5'd12;
    tick();
    i_issue_en = 1'b0;
    setReq(1, 5'd12, 64'h5555); i_req_valid = 3'b010;
    tick();
    i_req_valid = 3'b000;
    #1;
    nChecks++; if (o_rf_rd_en !== 1'b1) begin nFails++; $display("[TB] FAIL mid_rf_en_before: got %0h expected 1", o_rf_rd_en); end
    i_issue_en = 1'b1; i_issue_addr = 5'd13;
    tick();
    i_issue_en = 1'b0; i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1; i_rs1_addr = 5'd13; i_rs2_addr = 5'd12;
    #1;
    nChecks++; if (o_rf_rd_en !== 1'b0) begin nFails++; $display("[TB] FAIL mid_rf_en: got %0h expected 0", o_rf_rd_en); end
    nChecks++; if (o_rf_rd_addr !== 5'd0) begin nFails++; $display("[TB] FAIL mid_rf_addr: got %0d expected 0", o_rf_rd_addr); end
    nChecks++; if (o_rs1_busy !== 1'b0) begin nFails++; $display("[TB] FAIL mid_busy_cleared: got %0h expected 0", o_rs1_busy); end
    i_req_valid = 3'b111;
    #1;
    nChecks++; if (o_req_ready !== 3'b001) begin nFails++; $display("[TB] FAIL mid_ptr_reset: got %b expected 001", o_req_ready); end
    i_req_valid = 3'b000;
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_basic_write();
    test_round_robin();
    test_x0_write();
    test_set_clear_same();
    test_bypass();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/cprv_wb_arbiter.md
Name: cprv_wb_arbiter

Overview:
- Shares the single register-file write port (rd_addr/rd_data/rd_en) between NUM_REQ writeback sources, e.g. ALU, LSU and MUL/DIV.
- Round-robin grant with a valid/ready handshake per requester; the winning write is registered, then driven to the regfile one cycle later.
- Holds a per-register busy scoreboard: set at issue, cleared at commit. The issue stage uses it for RAW/WAW hazard stalls.

Parameters:
- DATA_WIDTH, 64, register data width.
- ADDR_WIDTH, 5, register address width.
- NUM_REQ, 3, number of writeback requesters (2..8).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  requester i holds a write.
- req_ready  out  NUM_REQ  requester i granted this cycle.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed destination addresses; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  packed write data.
- issue_en  in  1  instruction with rd issued this cycle.
- issue_addr  in  ADDR_WIDTH  rd of the issued instruction.
- rs1_addr, rs2_addr  in  ADDR_WIDTH  source registers being read by the issue stage.
- rs1_busy, rs2_busy  out  1  source has a pending write.
- rd_busy  out  1  busy[issue_addr] (WAW stall indication).
- rs1_fwd_valid, rs2_fwd_valid  out  1  forward hit (see Optional Feature).
- rs1_fwd_data, rs2_fwd_data  out  DATA_WIDTH  forwarded data.
- rf_rd_addr  out  ADDR_WIDTH  to regfile rd_addr.
- rf_rd_data  out  DATA_WIDTH  to regfile rd_data.
- rf_rd_en  out  1  to regfile rd_en.

Behaviour:
- Reset (rst_n low at posedge):
  - rr_ptr=0 and busy[]=0.
  - rf_rd_en=0, rf_rd_addr=0, rf_rd_data=0.
  - All fwd outputs are 0. req_ready is combinational and follows req_valid after reset.
- Arbitration (combinational):
  - Scan from rr_ptr upward, modulo NUM_REQ. The first requester with req_valid set gets req_ready=1; all others get 0.
  - No valid requester: req_ready=0.
  - req_ready never depends on rf state; the write port accepts one write every cycle.
- Handshake: transfer occurs when req_valid&req_ready. A requester must hold valid/addr/data stable until it sees ready.
- Pointer: on a transfer by requester g, rr_ptr <= (g+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Write stage (1-cycle latency):
  - On a transfer with address != 0: rf_rd_en<=1, rf_rd_addr<=req_addr[g], rf_rd_data<=req_data[g].
  - Otherwise rf_rd_en<=0; addr/data hold their last value.
  - Writes to x0 are accepted (ready=1) but never produce rf_rd_en.
- Scoreboard update, at each posedge:
  - If rf_rd_en: clear busy[rf_rd_addr].
  - If issue_en and issue_addr != 0: set busy[issue_addr].
  - Same address set and cleared in one cycle: the set wins (new writer pending).
  - busy[0] is constant 0.
- Hazard outputs (combinational): rs1_busy=busy[rs1_addr], rs2_busy=busy[rs2_addr], rd_busy=busy[issue_addr].
  - The issue stage must not assert issue_en while rd_busy=1. If it does, busy stays 1 and no error is flagged.
- Timing:
  - Regfile writes on the same edge that clears busy. Without bypass, a dependent read sees the new data the cycle after rf_rd_en.
  - Total latency from a requester transfer to the busy bit clearing is 2 edges.
- Reset mid-operation: the pending rf_rd_en is dropped and every busy bit is cleared. Upstream must flush in-flight instructions.

Optional Feature:
- Macro: CPRV_WB_BYPASS_EN.
- Defined:
  - When rf_rd_en=1, rf_rd_addr==rs1_addr and rs1_addr!=0: rs1_fwd_valid=1, rs1_fwd_data=rf_rd_data, rs1_busy=0. The same rule applies to rs2.
  - This removes one stall cycle for back-to-back dependencies.
- Undefined: fwd_valid/fwd_data are tied to 0 and busy follows the scoreboard only. Ports exist in both builds.

Test Plan:
- Reset, then req_valid=3'b000, rs1_addr=5: rf_rd_en=0, rs1_busy=0, req_ready=0, all fwd outputs 0.
- issue_en, issue_addr=7; then req0 valid with addr 7, data 0xDEAD:
  - req_ready[0]=1.
  - Next cycle rf_rd_en=1, rf_rd_addr=7, rf_rd_data=0xDEAD, rs1_busy(rs1_addr=7)=1.
  - Following cycle rs1_busy=0.
- req_valid=3'b111 held for 6 cycles, all requesters re-asserting after ready: grants rotate 0,1,2,0,1,2, exactly one req_ready per cycle.
- Write to addr 0 with data 0xFFFF: req_ready=1, rf_rd_en stays 0; issue_en addr 0 never sets busy.
- Same cycle: rf_rd_en clearing addr 9 and issue_en addr 9: busy[9]=1 afterwards.
- With CPRV_WB_BYPASS_EN, rf_rd_en to addr 4 data 0x1234 and rs2_addr=4: rs2_fwd_valid=1, rs2_fwd_data=0x1234, rs2_busy=0 in that cycle. Without the macro: rs2_busy=1, fwd_valid=0.
